reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised W-bit, 2**A-entry register file for the soft-core datapath. It has one write port, two registered read ports with write-to-read bypass, and a pending-write scoreboard. The decoder claims a destination when it issues a multi-cycle operation. The write-back clears the claim. Each read port reports whether its operand is ready, so the issue stage stalls on pending sources.

## Interface
Parameters:
- W, 8: data width in bits.
- A, 4: address width; number of registers N = 2**A.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- reg_ena  in  1  write enable.
- rd  in  A  write address.
- data  in  W  write data.
- claim_ena  in  1  mark a register as pending.
- claim_rd  in  A  address to claim.
- rd_ena  in  1  read enable; when low, s, t, s_rdy and t_rdy hold their values.
- rs  in  A  read address for port s.
- rt  in  A  read address for port t.
- s  out  W  registered read data, port s.
- t  out  W  registered read data, port t.
- s_rdy  out  1  operand s has no pending write.
- t_rdy  out  1  operand t has no pending write.
- pend_cnt  out  A+1  number of registers currently pending.

## Operation
- Register 0 is hardwired to zero. Writes and claims to address 0 are ignored. A read of address 0 returns 0 with rdy=1.
- Write: when reg_ena=1 and rd≠0, r[rd] ← data and pending[rd] ← 0.
- Claim: when claim_ena=1 and claim_rd≠0, pending[claim_rd] ← 1.
- Claim and write to the same address in one cycle: the data is written and pending ends at 1, because the claim belongs to a newer producer.
- Claim of an already-pending register: no change.
- Write to a non-pending register: legal, and pending stays 0.
- Read, when rd_ena=1, for each port x ∈ {s,t} with address a ∈ {rs,rt}:
  - x ← data if reg_ena=1 and rd=a≠0 (bypass); otherwise x ← r[a].
  - x_rdy ← inverse of pending[a] as it stands after this edge's write and claim updates. So a same-cycle write gives rdy=1, and a same-cycle claim gives rdy=0.
- pend_cnt equals the population count of pending[N-1:1] and is updated in the same edge as the pending bits. Its range is 0..N-1, so it never wraps.
- Reset, at any time including mid-operation:
  - All r[i] = 0 and all pending bits = 0.
  - s = t = 0, s_rdy = t_rdy = 1, pend_cnt = 0.
  - Reset takes effect immediately, without waiting for clk. Any write or claim in flight is lost.

## Timing
- Read latency is 1 cycle: the address is sampled at edge k, and data/rdy are valid after edge k.
- Write-to-read latency is 0 extra cycles because of the bypass. A read at the same edge as the write returns the new data.
- Claim-to-rdy: a read issued in the same cycle as the claim already sees rdy=0.
- pend_cnt reflects all updates made at edge k immediately after edge k.
- There are no combinational paths from inputs to outputs. All outputs are driven by flops.

## Structure
- Package reg_file_pkg holds:
  - Default W and A.
  - A function popcount(N-bit) for pend_cnt.
  - The constant ZERO_REG = 0.
- Sub-module reg_file_scoreboard (params A) holds:
  - The pending bit vector, claim/clear priority and pend_cnt.
  - Ports: clk, reset, set_ena/set_addr, clr_ena/clr_addr, and a lookup pair returning next-state pending for rs/rt.
- The top level holds the data array, bypass muxes and output registers. The data array is N-1 flops, not inferred RAM, because of the asynchronous reset.

## Test plan
- Reset then read: assert reset mid-stream after writing r5=0x3C. Read rs=5, rt=0. Required: s=0, t=0, s_rdy=t_rdy=1, pend_cnt=0.
- Write/read: write r3=0xA5, then next cycle read rs=3, rt=3. Required: s=t=0xA5, rdy=1.
- Bypass: reg_ena=1, rd=7, data=0x5A with rs=7 in the same cycle, where r7 previously held 0x11. Required after the edge: s=0x5A.
- Scoreboard: claim r4, then r9, then read rs=4, rt=9. Required: s_rdy=t_rdy=0, pend_cnt=2. Then write r4=0x22 with rs=4. Required: s=0x22, s_rdy=1, pend_cnt=1.
- Simultaneous events:
  - Claim and write r6 in the same cycle with rs=6. Required: s=new data, s_rdy=0, pend_cnt increments by 1.
  - Claim and write to r0. Required: r0 reads 0, pend_cnt unchanged.
- Hold: claim all registers 1..N-1 (pend_cnt=N-1). Then rd_ena=0 while changing rs/rt. Required: s, t, rdy unchanged, pend_cnt=N-1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the soft-core register file.
//   W_DEF / A_DEF : default data and address widths
//   ZERO_REG      : index of the hardwired-zero register
//   popcount()    : number of set bits, used for the pending count
package reg_file_pkg;

  localparam int W_DEF    = 8;
  localparam int A_DEF    = 4;
  localparam int ZERO_REG = 0;

  // popcount takes a fixed-width vector. Callers zero-extend into it,
  // so this limits the address width to 8 bits (256 registers).
  localparam int POP_MAX  = 256;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a claim and
// cleared by a write-back. A claim wins over a clear to the same address,
// because the claim belongs to the newer producer.
//   clk, reset          : clock, async active-high reset
//   set_ena / set_addr  : claim a register (mark it pending)
//   clr_ena / clr_addr  : write-back (clear pending)
//   lk_s_addr/lk_s_pend : lookup of the post-edge pending bit, port s
//   lk_t_addr/lk_t_pend : lookup of the post-edge pending bit, port t
//   pend_cnt            : registered count of pending registers
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_ena,
  input  logic [A-1:0] set_addr,
  input  logic         clr_ena,
  input  logic [A-1:0] clr_addr,
  input  logic [A-1:0] lk_s_addr,
  input  logic [A-1:0] lk_t_addr,
  output logic         lk_s_pend,
  output logic         lk_t_pend,
  output logic [A:0]   pend_cnt
);

  localparam int N = 1 << A;

  logic [N-1:0]       pend;
  logic [N-1:0]       pend_nxt;
  logic [POP_MAX-1:0] pend_ext;

  // Clear first, then set, so a simultaneous claim leaves the bit at 1.
  always_comb begin
    pend_nxt = pend;
    if (clr_ena && clr_addr != A'(ZERO_REG)) pend_nxt[clr_addr] = 1'b0;
    if (set_ena && set_addr != A'(ZERO_REG)) pend_nxt[set_addr] = 1'b1;
    pend_nxt[ZERO_REG] = 1'b0;
  end

  always_comb begin
    pend_ext          = '0;
    pend_ext[N-1:0]   = pend_nxt;
  end

  // The readers sample the next-state bit, so a same-cycle claim or write
  // is already visible in the registered rdy outputs.
  assign lk_s_pend = pend_nxt[lk_s_addr];
  assign lk_t_pend = pend_nxt[lk_t_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= (A+1)'(popcount(pend_ext));
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// W-bit, 2**A-entry register file. It has one write port and two registered
// read ports with write-to-read bypass. A pending-write scoreboard drives
// the per-port ready flags. Register 0 reads as zero and ignores writes.
//   clk, reset         : clock, async active-high reset
//   reg_ena, rd, data  : write port
//   claim_ena,claim_rd : mark a destination pending
//   rd_ena, rs, rt     : read request; outputs hold while rd_ena is low
//   s, t               : registered read data
//   s_rdy, t_rdy       : registered "operand has no pending write"
//   pend_cnt           : number of pending registers
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reg_ena,
  input  logic [A-1:0] rd,
  input  logic [W-1:0] data,
  input  logic         claim_ena,
  input  logic [A-1:0] claim_rd,
  input  logic         rd_ena,
  input  logic [A-1:0] rs,
  input  logic [A-1:0] rt,
  output logic [W-1:0] s,
  output logic [W-1:0] t,
  output logic         s_rdy,
  output logic         t_rdy,
  output logic [A:0]   pend_cnt
);

  localparam int N = 1 << A;

  // Flop array rather than RAM, because every entry clears on async reset.
  // Entry 0 is reset and never written, so synthesis folds it to a constant.
  logic [W-1:0] r [N];

  logic         wr_live;
  logic         s_pend;
  logic         t_pend;
  logic [W-1:0] s_nxt;
  logic [W-1:0] t_nxt;

  assign wr_live = reg_ena && (rd != A'(ZERO_REG));

  reg_file_scoreboard #(.A(A)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_ena   (claim_ena),
    .set_addr  (claim_rd),
    .clr_ena   (reg_ena),
    .clr_addr  (rd),
    .lk_s_addr (rs),
    .lk_t_addr (rt),
    .lk_s_pend (s_pend),
    .lk_t_pend (t_pend),
    .pend_cnt  (pend_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (wr_live && rd == A'(i)) r[i] <= data;
      end
    end
  end

  // Bypass: a read of the address being written returns the incoming data.
  always_comb begin
    s_nxt = r[rs];
    t_nxt = r[rt];
    if (wr_live && rd == rs) s_nxt = data;
    if (wr_live && rd == rt) t_nxt = data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s     <= '0;
      t     <= '0;
      s_rdy <= 1'b1;
      t_rdy <= 1'b1;
    end else if (rd_ena) begin
      s     <= s_nxt;
      t     <= t_nxt;
      s_rdy <= ~s_pend;
      t_rdy <= ~t_pend;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int W = 8;
  localparam int A = 4;
  localparam int N = 1 << A;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_ena;
  logic [A-1:0] rd;
  logic [W-1:0] data;
  logic         claim_ena;
  logic [A-1:0] claim_rd;
  logic         rd_ena;
  logic [A-1:0] rs;
  logic [A-1:0] rt;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic         s_rdy;
  logic         t_rdy;
  logic [A:0]   pend_cnt;

  reg_file_sb #(.W(W), .A(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_ena   (reg_ena),
    .rd        (rd),
    .data      (data),
    .claim_ena (claim_ena),
    .claim_rd  (claim_rd),
    .rd_ena    (rd_ena),
    .rs        (rs),
    .rt        (rt),
    .s         (s),
    .t         (t),
    .s_rdy     (s_rdy),
    .t_rdy     (t_rdy),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         s_rdy;
    logic         t_rdy;
    logic [A:0]   cnt;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;

  // reference model
  logic [W-1:0] m_r [N];
  logic [N-1:0] m_p;
  exp_t         m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [A:0] m_count(input logic [N-1:0] p);
    logic [A:0] c;
    c = '0;
    for (int i = 1; i < N; i++) if (p[i]) c = c + 1'b1;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_r[i] = '0;
    m_p         = '0;
    m_out.s     = '0;
    m_out.t     = '0;
    m_out.s_rdy = 1'b1;
    m_out.t_rdy = 1'b1;
    m_out.cnt   = '0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".s"},    32'(s),        32'(e.s));
    chk({tag, ".t"},    32'(t),        32'(e.t));
    chk({tag, ".srdy"}, 32'(s_rdy),    32'(e.s_rdy));
    chk({tag, ".trdy"}, 32'(t_rdy),    32'(e.t_rdy));
    chk({tag, ".cnt"},  32'(pend_cnt), 32'(e.cnt));
  endtask

  // One clock of stimulus: drive at negedge, push the model's prediction,
  // then pop and compare just after the rising edge.
  task automatic step(input string tag,
                      input logic we, input logic [A-1:0] wa, input logic [W-1:0] wd,
                      input logic cl, input logic [A-1:0] ca,
                      input logic re, input logic [A-1:0] ra, input logic [A-1:0] rb);
    logic [N-1:0] np;
    exp_t         e;
    @(negedge clk);
    reg_ena = we; rd = wa; data = wd;
    claim_ena = cl; claim_rd = ca;
    rd_ena = re; rs = ra; rt = rb;

    np = m_p;
    if (we && wa != 0) np[wa] = 1'b0;
    if (cl && ca != 0) np[ca] = 1'b1;
    if (re) begin
      m_out.s     = (ra == 0) ? '0 : ((we && wa == ra) ? wd : m_r[ra]);
      m_out.t     = (rb == 0) ? '0 : ((we && wa == rb) ? wd : m_r[rb]);
      m_out.s_rdy = ~np[ra];
      m_out.t_rdy = ~np[rb];
    end
    if (we && wa != 0) m_r[wa] = wd;
    m_p       = np;
    m_out.cnt = m_count(np);
    exp_q.push_back(m_out);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, ".queue"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  task automatic idle();
    step("idle", 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reg_ena = 1'b0; rd = '0; data = '0;
    claim_ena = 1'b0; claim_rd = '0;
    rd_ena = 1'b0; rs = '0; rt = '0;
    m_reset();
    #23;
    check_outputs("rst_init", m_out);
    @(negedge clk);
    reset = 1'b0;

    // write r5, read it back, then reset mid-cycle and check async effect
    step("w5",   1'b1, 4'd5, 8'h3C, 1'b0, '0, 1'b0, '0, '0);
    step("r5",   1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd5, 4'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check_outputs("rst_async", m_out);
    @(negedge clk);
    reset = 1'b0;
    step("r5_post", 1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd5, 4'd0);

    // write then read
    step("w3",   1'b1, 4'd3, 8'hA5, 1'b0, '0, 1'b0, '0, '0);
    step("r33",  1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd3, 4'd3);

    // bypass over an older value
    step("w7",   1'b1, 4'd7, 8'h11, 1'b0, '0, 1'b0, '0, '0);
    step("byp7", 1'b1, 4'd7, 8'h5A, 1'b0, '0, 1'b1, 4'd7, 4'd3);

    // scoreboard claims and clear by write-back
    step("cl4",  1'b0, '0, '0, 1'b1, 4'd4, 1'b0, '0, '0);
    step("cl9",  1'b0, '0, '0, 1'b1, 4'd9, 1'b0, '0, '0);
    step("r49",  1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd4, 4'd9);
    step("wb4",  1'b1, 4'd4, 8'h22, 1'b0, '0, 1'b1, 4'd4, 4'd9);
    step("recl9", 1'b0, '0, '0, 1'b1, 4'd9, 1'b1, 4'd9, 4'd4);

    // simultaneous claim and write
    step("cw6",  1'b1, 4'd6, 8'h77, 1'b1, 4'd6, 1'b1, 4'd6, 4'd0);
    step("cw0",  1'b1, 4'd0, 8'hFF, 1'b1, 4'd0, 1'b1, 4'd0, 4'd0);
    step("wnp3", 1'b1, 4'd3, 8'h3B, 1'b0, '0, 1'b1, 4'd3, 4'd6);

    // claim every register, then hold the read outputs
    for (int i = 1; i < N; i++)
      step("clall", 1'b0, '0, '0, 1'b1, 4'(i), 1'b0, '0, '0);
    step("rall", 1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd6, 4'd0);
    for (int i = 0; i < 4; i++)
      step("hold", 1'b0, '0, '0, 1'b0, '0, 1'b0, 4'(i + 1), 4'(15 - i));

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, N-1)), 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, N-1)),
           1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, N-1)),
           4'($urandom_range(0, N-1)));

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
